// File: rtl/bit_pair_packer_pkg.sv
// Shared types and widths for the bit-pair packer: FSM states, pair width
// and the FIFO entry layout {pair[1:0], last}.
package bit_pair_packer_pkg;

    localparam int PAIR_W  = 2;
    localparam int ENTRY_W = PAIR_W + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

    // The earlier serial bit lands in the MSB of the pair; last rides in bit 0.
    function automatic logic [ENTRY_W-1:0] make_entry(
        input logic first_bit,
        input logic second_bit,
        input logic last
    );
        return {first_bit, second_bit, last};
    endfunction

endpackage

// File: rtl/bit_pair_packer_fifo.sv
// Circular FIFO holding packed pair entries. The read data is forced to zero
// while empty so an idle output never carries stale ones downstream.
module pair_fifo
    import bit_pair_packer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] rptr_d;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Guarded push/pop and next pointer/level; pointers wrap by natural overflow.
    always_comb begin
        do_push_s = push_i && (level_q != FULL_LVL);
        do_pop_s  = pop_i && (level_q != {LVL_W{1'b0}});
        if (do_push_s) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            level_q <= {LVL_W{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Entry storage, cleared on reset so discarded pairs cannot resurface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = (level_q != {LVL_W{1'b0}}) ? mem_q[rptr_q] : {WIDTH{1'b0}};
    assign level_o    = level_q;

endmodule

// File: rtl/bit_pair_packer.sv
// Packs a serial bit stream into 2-bit pairs (earlier bit in MSB), padding an
// odd-length frame with a 0, and queues the pairs in a small output FIFO.
module bit_pair_packer
    import bit_pair_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     bit_last,
    output logic                     bit_ready,
    output logic [PAIR_W-1:0]        pair_out,
    output logic                     pair_valid,
    output logic                     pair_last,
    input  logic                     pair_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    pack_state_e          state_q;
    pack_state_e          state_d;
    logic                 hold_q;
    logic                 hold_d;
    logic                 bit_xfer_s;
    logic                 push_s;
    logic [ENTRY_W-1:0]   push_entry_s;
    logic                 pop_s;
    logic [ENTRY_W-1:0]   pop_entry_s;
    logic [LVL_W-1:0]     level_s;

    assign bit_ready  = (level_s != FULL_LVL);
    assign pair_valid = (level_s != {LVL_W{1'b0}});
    assign bit_xfer_s = bit_valid && bit_ready;
    assign pop_s      = pair_valid && pair_ready;

    // Packing FSM next state; a push is issued straight into the FIFO on the transfer edge.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        push_s       = 1'b0;
        push_entry_s = {ENTRY_W{1'b0}};
        if (bit_xfer_s) begin
            case (state_q)
                EMPTY: begin
                    if (bit_last) begin
                        push_s       = 1'b1;
                        push_entry_s = make_entry(bit_in, 1'b0, 1'b1);
                        state_d      = EMPTY;
                    end else begin
                        hold_d  = bit_in;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    push_s       = 1'b1;
                    push_entry_s = make_entry(hold_q, bit_in, bit_last);
                    state_d      = EMPTY;
                end
                default: begin
                    state_d = EMPTY;
                    hold_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
            hold_d  = hold_q;
        end
    end

    // FSM state and hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .pop_data_o  (pop_entry_s),
        .level_o     (level_s)
    );

    assign pair_out  = pop_entry_s[ENTRY_W-1:1];
    assign pair_last = pop_entry_s[0];
    assign level     = level_s;

endmodule
